// File: rtl/udp_128bit_recv_if.sv
// Byte stream from the UDP RX core plus the 128-bit word write bus toward DDR3.
interface udp_128bit_recv_if;
    logic         i_udp_rx_de;
    logic [7:0]   i_udp_rx_data;
    logic         i_udp_rx_sof;
    logic         i_udp_rx_eof;
    logic [15:0]  i_udp_rx_len;
    logic [127:0] o_ddr3_wrdata;
    logic         o_ddr3_wr_req;
    logic [15:0]  o_ddr3_byte_en;
    logic [6:0]   o_wr_128_rank;

    // Source side: drives the byte stream, consumes packed words.
    modport master (
        output i_udp_rx_de, i_udp_rx_data, i_udp_rx_sof, i_udp_rx_eof, i_udp_rx_len,
        input  o_ddr3_wrdata, o_ddr3_wr_req, o_ddr3_byte_en, o_wr_128_rank
    );

    // Unpacker side.
    modport slave (
        input  i_udp_rx_de, i_udp_rx_data, i_udp_rx_sof, i_udp_rx_eof, i_udp_rx_len,
        output o_ddr3_wrdata, o_ddr3_wr_req, o_ddr3_byte_en, o_wr_128_rank
    );
endinterface

// File: rtl/udp_128bit_recv.sv
// UDP payload unpacker: parses the 2-byte frame header, then packs JPEG bytes
// (first byte in the MSB) into 128-bit words with a one-cycle write request each.
module udp_128bit_recv #(
    parameter int MAX_JPEG_LEN = 2048,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              i_udp_clk50m,
    input  logic              i_rst_n,
    input  logic              i_en,
    udp_128bit_recv_if.slave  bus,
    output logic              o_last_frame_flag,
    output logic [14:0]       o_mjpeg_frame_rank,
    output logic [15:0]       o_jpeg_len,
    output logic              o_pkt_done,
    output logic              o_pkt_err,
    output logic              o_busy,
    output logic [3:0]        o_state
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HEAD_LO = 4'd1,
        S_DATA    = 4'd2,
        S_DROP    = 4'd3,
        S_DONE    = 4'd4
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     hdr_hi_q, hdr_hi_d;
    logic [15:0]    jlen_q, jlen_d;          // len - 2 of the packet being received
    logic           flag_q, flag_d;
    logic [14:0]    frank_q, frank_d;
    logic [15:0]    jpeg_len_q, jpeg_len_d;  // published copy, updated on header completion
    logic [15:0]    cnt_q, cnt_d;
    logic [3:0]     slot_q, slot_d;
    logic [6:0]     rank_q, rank_d;
    logic [127:0]   buf_q, buf_d;
    logic [127:0]   wrdata_q, wrdata_d;
    logic           wr_req_q, wr_req_d;
    logic [15:0]    byte_en_q, byte_en_d;
    logic [6:0]     wr_rank_q, wr_rank_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;

    logic           de, sof, eof;
    logic           try_sof, bad_len, last_byte, timeout;
    logic [6:0]     byte_lsb;

    assign de  = bus.i_udp_rx_de;
    assign sof = bus.i_udp_rx_de & bus.i_udp_rx_sof;
    assign eof = bus.i_udp_rx_de & bus.i_udp_rx_eof;

    assign bad_len   = (bus.i_udp_rx_len < 16'd3) ||
                       ({1'b0, bus.i_udp_rx_len} > 17'(MAX_JPEG_LEN + 2));
    assign last_byte = (cnt_q == jlen_q - 16'd1);
    assign timeout   = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign byte_lsb  = {4'd15 - slot_q, 3'b000};

    // Next-state, packing and pulse generation.
    always_comb begin
        state_d    = state_q;
        hdr_hi_d   = hdr_hi_q;
        jlen_d     = jlen_q;
        flag_d     = flag_q;
        frank_d    = frank_q;
        jpeg_len_d = jpeg_len_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        rank_d     = rank_q;
        buf_d      = buf_q;
        wrdata_d   = wrdata_q;
        byte_en_d  = byte_en_q;
        wr_rank_d  = wr_rank_q;
        busy_d     = busy_q;
        wr_req_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        try_sof    = 1'b0;

        // Idle-gap counter only runs while a packet is open.
        to_cnt_d = '0;
        if ((state_q == S_HEAD_LO || state_q == S_DATA || state_q == S_DROP) && !de)
            to_cnt_d = to_cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                try_sof = sof;
            end
            S_HEAD_LO: begin
                if (sof || eof || (!de && timeout)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    try_sof = sof;
                end else if (de) begin
                    flag_d     = hdr_hi_q[7];
                    frank_d    = {hdr_hi_q[6:0], bus.i_udp_rx_data};
                    jpeg_len_d = jlen_q;
                    cnt_d      = '0;
                    slot_d     = '0;
                    rank_d     = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (sof || (!de && timeout)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    try_sof = sof;
                end else if (de) begin
                    if (slot_q == 4'd0) buf_d = '0;
                    buf_d[byte_lsb +: 8] = bus.i_udp_rx_data;
                    slot_d = slot_q + 4'd1;
                    if (!last_byte) cnt_d = cnt_q + 16'd1;
                    // A complete word goes out even if eof arrives early; only partial ones are lost.
                    if (slot_q == 4'd15 || last_byte) begin
                        wr_req_d  = 1'b1;
                        wrdata_d  = buf_d;
                        byte_en_d = 16'hFFFF << (4'd15 - slot_q);
                        wr_rank_d = rank_q;
                        rank_d    = rank_q + 7'd1;
                    end
                    if (last_byte) begin
                        if (eof) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (eof) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (sof || eof || (!de && timeout)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    try_sof = sof;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // New packet start: also reached from an abort caused by a sof mid-packet.
        if (try_sof && i_en) begin
            hdr_hi_d = bus.i_udp_rx_data;
            jlen_d   = bus.i_udp_rx_len - 16'd2;
            busy_d   = 1'b1;
            state_d  = bad_len ? S_DROP : S_HEAD_LO;
            if (eof) begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            hdr_hi_q   <= '0;
            jlen_q     <= '0;
            flag_q     <= 1'b0;
            frank_q    <= '0;
            jpeg_len_q <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            rank_q     <= '0;
            buf_q      <= '0;
            wrdata_q   <= '0;
            wr_req_q   <= 1'b0;
            byte_en_q  <= '0;
            wr_rank_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            jlen_q     <= jlen_d;
            flag_q     <= flag_d;
            frank_q    <= frank_d;
            jpeg_len_q <= jpeg_len_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            rank_q     <= rank_d;
            buf_q      <= buf_d;
            wrdata_q   <= wrdata_d;
            wr_req_q   <= wr_req_d;
            byte_en_q  <= byte_en_d;
            wr_rank_q  <= wr_rank_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.o_ddr3_wrdata  = wrdata_q;
    assign bus.o_ddr3_wr_req  = wr_req_q;
    assign bus.o_ddr3_byte_en = byte_en_q;
    assign bus.o_wr_128_rank  = wr_rank_q;
    assign o_last_frame_flag  = flag_q;
    assign o_mjpeg_frame_rank = frank_q;
    assign o_jpeg_len         = jpeg_len_q;
    assign o_pkt_done         = done_q;
    assign o_pkt_err          = err_q;
    assign o_busy             = busy_q;
    assign o_state            = state_q;
endmodule
